// File: rtl/flash_pkg.sv
// Shared encodings and widths for the flash-to-RAM boot loader.
package flash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

  localparam int FLASH_BYTE_W = 8;
  localparam int CKSUM_W      = 16;

endpackage

// File: rtl/flash2ram_lane_dec.sv
// Byte-counter low bits to one-hot RAM byte-lane enable, with selectable lane order.
module flash2ram_lane_dec #(
  parameter int BPW        = 4,
  parameter bit BIG_ENDIAN = 1'b0,
  localparam int LB        = $clog2(BPW)
) (
  input  logic [LB-1:0]  idx_i,
  output logic [BPW-1:0] onehot_o
);

  logic [LB-1:0] lane;

  always_comb begin
    // BPW is a power of two, so BPW-1-idx is simply the bitwise inverse.
    lane            = BIG_ENDIAN ? ~idx_i : idx_i;
    onehot_o        = '0;
    onehot_o[lane]  = 1'b1;
  end

endmodule

// File: rtl/flash2ram_loader.sv
// Boot loader: packs flash bytes into IMEM words via byte-lane write enables.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   LOAD  | accepting bytes from the flash reader, core held in reset
//   DONE  | byte_len bytes written, waiting for a new start
module flash2ram_loader
  import flash_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int BPW        = 4,
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int LEN_W      = 19
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [LEN_W-1:0]          byte_len,
  input  logic [FLASH_BYTE_W-1:0]   flash_rdata,
  input  logic                      flash_rdata_valid,
  output logic                      flash_rd_en,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [BPW-1:0]            ram_wen,
  output logic [FLASH_BYTE_W*BPW-1:0] ram_din,
  output logic                      busy,
  output logic                      done,
  output logic [CKSUM_W-1:0]        checksum,
  output logic                      err_overrun
);

  localparam int LB = $clog2(BPW);

  ld_state_e                   state_q, state_d;
  logic [LEN_W-1:0]            cnt_q, cnt_d;
  logic [LEN_W-1:0]            len_q, len_d;
  logic [ADDR_W-1:0]           base_q, base_d;
  logic [CKSUM_W-1:0]          cksum_q, cksum_d;
  logic                        err_q, err_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [BPW-1:0]              wen_q, wen_d;
  logic [FLASH_BYTE_W*BPW-1:0] din_q, din_d;
  logic [BPW-1:0]              lane_oh;

  flash2ram_lane_dec #(
    .BPW        (BPW),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane_dec (
    .idx_i    (cnt_q[LB-1:0]),
    .onehot_o (lane_oh)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    base_d  = base_q;
    cksum_d = cksum_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wen_d   = '0;
    din_d   = din_q;
    case (state_q)
      ST_LOAD: begin
        // Counter never passes byte_len: the last byte moves us out of LOAD.
        if (flash_rdata_valid && (cnt_q < len_q)) begin
          cnt_d   = cnt_q + 1'b1;
          cksum_d = cksum_q + CKSUM_W'(flash_rdata);
          wen_d   = lane_oh;
          addr_d  = base_q + ADDR_W'(cnt_q >> LB);
          din_d   = {BPW{flash_rdata}};
          if (cnt_d == len_q) state_d = ST_DONE;
        end
      end
      default: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = byte_len;
          cnt_d   = '0;
          cksum_d = '0;
          err_d   = 1'b0;
          state_d = (byte_len == '0) ? ST_DONE : ST_LOAD;
        end
        if (flash_rdata_valid) err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      cksum_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wen_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      base_q  <= base_d;
      cksum_q <= cksum_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      din_q   <= din_d;
    end
  end

  assign busy        = (state_q == ST_LOAD);
  assign flash_rd_en = busy;
  assign done        = (state_q == ST_DONE);
  assign checksum    = cksum_q;
  assign err_overrun = err_q;
  assign ram_addr    = addr_q;
  assign ram_wen     = wen_q;
  assign ram_din     = din_q;

endmodule

// File: tb/tb_flash2ram_loader.sv
// Randomized directed bench for flash2ram_loader (LE and BE instances side by side).
module tb_flash2ram_loader;

  localparam int ADDR_W = 17;
  localparam int BPW    = 4;
  localparam int LEN_W  = 19;
  localparam int AMASK  = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  byte_len = '0;
  logic [7:0]        flash_rdata = '0;
  logic              flash_rdata_valid = 1'b0;

  logic              le_rd_en, le_busy, le_done, le_err;
  logic [ADDR_W-1:0] le_addr;
  logic [BPW-1:0]    le_wen;
  logic [31:0]       le_din;
  logic [15:0]       le_cksum;

  logic              be_rd_en, be_busy, be_done, be_err;
  logic [ADDR_W-1:0] be_addr;
  logic [BPW-1:0]    be_wen;
  logic [31:0]       be_din;
  logic [15:0]       be_cksum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  flash2ram_loader #(.ADDR_W(ADDR_W), .BPW(BPW), .BIG_ENDIAN(1'b0), .LEN_W(LEN_W)) u_le (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .byte_len(byte_len),
    .flash_rdata(flash_rdata), .flash_rdata_valid(flash_rdata_valid),
    .flash_rd_en(le_rd_en), .ram_addr(le_addr), .ram_wen(le_wen), .ram_din(le_din),
    .busy(le_busy), .done(le_done), .checksum(le_cksum), .err_overrun(le_err));

  flash2ram_loader #(.ADDR_W(ADDR_W), .BPW(BPW), .BIG_ENDIAN(1'b1), .LEN_W(LEN_W)) u_be (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .byte_len(byte_len),
    .flash_rdata(flash_rdata), .flash_rdata_valid(flash_rdata_valid),
    .flash_rd_en(be_rd_en), .ram_addr(be_addr), .ram_wen(be_wen), .ram_din(be_din),
    .busy(be_busy), .done(be_done), .checksum(be_cksum), .err_overrun(be_err));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int base, input int len);
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    byte_len  = LEN_W'(len);
    step();
    start = 1'b0;
    chk("start_busy", le_busy, (len != 0));
    chk("start_rd_en", le_rd_en, (len != 0));
    chk("start_done", le_done, (len == 0));
    chk("start_err", le_err, 0);
    chk("start_cksum", le_cksum, 0);
    chk("start_wen", le_wen, 0);
  endtask

  // Streams len random bytes with gap idle cycles between them; the expected
  // word address, lane and checksum come from plain arithmetic on the byte index.
  task automatic run_load(input int base, input int len, input int gap, input bit mid_start);
    int   sum;
    int   b;
    int   exp_addr;
    sum = 0;
    do_start(base, len);
    for (int i = 0; i < len; i++) begin
      b = int'($urandom_range(0, 255));
      flash_rdata       = 8'(b);
      flash_rdata_valid = 1'b1;
      if (mid_start && i == 1) begin
        start     = 1'b1;
        base_addr = ADDR_W'(base + 100);
        byte_len  = LEN_W'(1);
      end
      step();
      flash_rdata_valid = 1'b0;
      start = 1'b0;
      sum = (sum + b) % 65536;
      exp_addr = (base + i / BPW) & AMASK;
      chk("le_wen", le_wen, 1 << (i % BPW));
      chk("be_wen", be_wen, 1 << (BPW - 1 - i % BPW));
      chk("le_addr", le_addr, exp_addr);
      chk("be_addr", be_addr, exp_addr);
      chk("le_din", le_din, b * 32'h0101_0101);
      chk("be_din", be_din, b * 32'h0101_0101);
      chk("cksum", le_cksum, sum);
      chk("be_cksum", be_cksum, sum);
      chk("busy", le_busy, (i != len - 1));
      chk("rd_en", le_rd_en, (i != len - 1));
      chk("done", le_done, (i == len - 1));
      if (i != len - 1) begin
        for (int g = 0; g < gap; g++) begin
          step();
          chk("gap_wen", le_wen, 0);
          chk("gap_addr_hold", le_addr, exp_addr);
        end
      end
    end
    step();
    chk("post_wen", le_wen, 0);
    chk("post_done", le_done, 1);
    chk("post_be_done", be_done, 1);
    chk("post_cksum", le_cksum, sum);
    chk("post_err", le_err, 0);
  endtask

  initial begin
    #12;
    chk("rst_busy", le_busy, 0);
    chk("rst_done", le_done, 0);
    chk("rst_wen", le_wen, 0);
    chk("rst_addr", le_addr, 0);
    chk("rst_din", le_din, 0);
    chk("rst_cksum", le_cksum, 0);
    chk("rst_err", le_err, 0);
    chk("rst_rd_en", le_rd_en, 0);
    rst_n = 1'b1;
    step();

    // Fixed bytes 01..08: checksum must be 0x24.
    do_start(32'h10, 8);
    for (int i = 0; i < 8; i++) begin
      flash_rdata = 8'(i + 1);
      flash_rdata_valid = 1'b1;
      step();
      flash_rdata_valid = 1'b0;
      chk("fix_wen", le_wen, 1 << (i % 4));
      chk("fix_addr", le_addr, 32'h10 + i / 4);
    end
    chk("fix_cksum", le_cksum, 16'h0024);
    chk("fix_done", le_done, 1);
    chk("fix_busy", le_busy, 0);
    step();

    run_load(32'h40, 4, 0, 1'b0);
    run_load(int'($urandom_range(0, 1000)), 6, 2, 1'b0);
    run_load(AMASK, 8, 0, 1'b0);
    run_load(int'($urandom_range(0, AMASK)), 11, int'($urandom_range(0, 3)), 1'b0);

    // Zero-length load, then an overrun in DONE cleared by the next start.
    do_start(32'h55, 0);
    step();
    chk("len0_done", le_done, 1);
    chk("len0_rd_en", le_rd_en, 0);
    chk("len0_wen", le_wen, 0);
    flash_rdata = 8'hAA;
    flash_rdata_valid = 1'b1;
    step();
    flash_rdata_valid = 1'b0;
    chk("ovr_err", le_err, 1);
    chk("ovr_wen", le_wen, 0);
    chk("ovr_cksum", le_cksum, 0);
    step();
    chk("ovr_sticky", le_err, 1);
    run_load(32'h200, 5, 1, 1'b0);

    // Start during LOAD must not disturb the load in progress.
    run_load(32'h300, 7, 1, 1'b1);

    // Async reset mid-load, then a clean reload.
    do_start(32'h500, 8);
    for (int i = 0; i < 3; i++) begin
      flash_rdata = 8'(i + 9);
      flash_rdata_valid = 1'b1;
      step();
    end
    chk("pre_rst_wen", le_wen, 4);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", le_busy, 0);
    chk("arst_wen", le_wen, 0);
    chk("arst_rd_en", le_rd_en, 0);
    chk("arst_cksum", le_cksum, 0);
    chk("arst_addr", le_addr, 0);
    flash_rdata_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("arst_err", le_err, 0);
    run_load(32'h600, 9, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
